fifo_ctrl: RTL and testbench

Pointer and flag controller that sits directly upstream of the dual-pointer `memory` block. It accepts push/pop requests and drives the memory's `write`, `read`, `wr_ptr` and `rd_ptr`. It maintains an occupancy count and full/empty/almost flags with thresholds loaded at init, and signals when the memory's `data_out` is valid. Write data passes straight from the producer to the memory and is not routed through this block.

---
 rtl/fifo_ctrl_pkg.sv | 14 +
 rtl/fifo_ptr.sv | 19 +
 rtl/fifo_ctrl.sv | 152 +++++++++++++++
 tb/tb_fifo_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO pointer/flag controller: FSM state encodings.
package fifo_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/fifo_ptr.sv
// MAIN_SIZE-bit wrapping address counter with increment enable.
module fifo_ptr #(
  parameter int MAIN_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [MAIN_SIZE-1:0] ptr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + MAIN_SIZE'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Push/pop pointer and flag controller for a dual-pointer memory.
// Optional sticky error detection and ERROR state: define FIFO_CTRL_ERR_EN.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int MAIN_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [MAIN_SIZE:0]   af_thresh,
  input  logic [MAIN_SIZE:0]   ae_thresh,
  input  logic                 push,
  input  logic                 pop,
  output logic                 write,
  output logic                 read,
  output logic [MAIN_SIZE-1:0] wr_ptr,
  output logic [MAIN_SIZE-1:0] rd_ptr,
  output logic                 data_valid,
  output logic [MAIN_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error,
  output logic [STATE_W-1:0]   state
);

  localparam int              CW    = MAIN_SIZE + 1;
  localparam logic [CW-1:0]   DEPTH = CW'(2 ** MAIN_SIZE);

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   af_q, af_d;
  logic [CW-1:0]   ae_q, ae_d;
  logic            full_q, empty_q, afull_q, aempty_q;
  logic            vld_p1;
  logic            accept_ok;
  logic            push_acc, pop_acc;
  logic            load_thr;
  logic            err_go;

  // Request acceptance: only IDLE/ACTIVE take traffic, gated by the registered flags
  assign accept_ok = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign push_acc  = push & ~full_q  & accept_ok;
  assign pop_acc   = pop  & ~empty_q & accept_ok;
  assign write     = push_acc;
  assign read      = pop_acc;

`ifdef FIFO_CTRL_ERR_EN
  logic err_evt;
  logic err_q;

  // A dropped push (full) or dropped pop (empty) is an error event
  assign err_evt = accept_ok & ((push & full_q) | (pop & empty_q));
  assign err_go  = err_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_evt) begin
      err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  assign err_go = 1'b0;
  assign error  = 1'b0;
`endif

  assign load_thr = (state_q == ST_INIT) || ((state_q == ST_IDLE) && init);
  assign af_d     = load_thr ? af_thresh : af_q;
  assign ae_d     = load_thr ? ae_thresh : ae_q;

  always_comb begin
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        // An accepted push wins over init so INIT is never entered with data held
        if (err_go)        state_d = ST_ERROR;
        else if (push_acc) state_d = ST_ACTIVE;
        else if (init)     state_d = ST_INIT;
      end
      ST_ACTIVE: begin
        if (err_go)              state_d = ST_ERROR;
        else if (count_d == '0)  state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
  end

  // Stage p1: count, thresholds, flags and read-valid all register on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RESET;
      count_q  <= '0;
      af_q     <= DEPTH;
      ae_q     <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      vld_p1   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      full_q   <= (count_d == DEPTH);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= af_d);
      aempty_q <= (count_d <= ae_d);
      vld_p1   <= pop_acc;
    end
  end

  fifo_ptr #(.MAIN_SIZE(MAIN_SIZE)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.MAIN_SIZE(MAIN_SIZE)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_acc),
    .ptr   (rd_ptr)
  );

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign data_valid   = vld_p1;
  assign state        = state_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl (MAIN_SIZE=3) with an attached behavioural memory.
module tb_fifo_ctrl;

  localparam int MS    = 3;
  localparam int DEPTH = 8;

  localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;
`ifdef FIFO_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          reset, init, push, pop;
  logic [MS:0]   af_thresh, ae_thresh;
  logic          write, read, data_valid;
  logic [MS-1:0] wr_ptr, rd_ptr;
  logic [MS:0]   count;
  logic          full, empty, almost_full, almost_empty, error;
  logic [2:0]    state;

  logic [15:0]   wdata, data_out;
  logic [15:0]   mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  int m_st, m_occ, m_wr, m_rd, m_af, m_ae, m_dv, m_err;
  logic [15:0] mq[$];
  logic [15:0] sb[$];

  fifo_ctrl #(.MAIN_SIZE(MS)) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .push         (push),
    .pop          (pop),
    .write        (write),
    .read         (read),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .data_valid   (data_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write) mem[wr_ptr] <= wdata;
    if (read)  data_out    <= mem[rd_ptr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every presented read word is matched against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("read_data", 32'(data_out), 32'(sb.pop_front()));
      end
    end
  end

  task automatic model_reset();
    m_st = S_RESET; m_occ = 0; m_wr = 0; m_rd = 0;
    m_af = DEPTH; m_ae = 0; m_dv = 0; m_err = 0;
    mq.delete();
    sb.delete();
  endtask

  task automatic check_regs();
    chk("count",        32'(count),        m_occ);
    chk("wr_ptr",       32'(wr_ptr),       m_wr);
    chk("rd_ptr",       32'(rd_ptr),       m_rd);
    chk("full",         32'(full),         32'(m_occ == DEPTH));
    chk("empty",        32'(empty),        32'(m_occ == 0));
    chk("almost_full",  32'(almost_full),  32'(m_occ >= m_af));
    chk("almost_empty", 32'(almost_empty), 32'(m_occ <= m_ae));
    chk("state",        32'(state),        m_st);
    chk("data_valid",   32'(data_valid),   m_dv);
    chk("error",        32'(error),        m_err);
  endtask

  task automatic drive(input bit p, input bit q, input bit i, input int afv, input int aev);
    bit ok, pa, qa, ev;
    push = p; pop = q; init = i;
    af_thresh = (MS+1)'(afv); ae_thresh = (MS+1)'(aev);
    wdata = 16'($urandom);
    ok = (m_st == S_IDLE) || (m_st == S_ACTIVE);
    pa = p && ok && (m_occ != DEPTH);
    qa = q && ok && (m_occ != 0);
    ev = ok && ((p && m_occ == DEPTH) || (q && m_occ == 0));
    #1;
    chk("write", 32'(write), 32'(pa));
    chk("read",  32'(read),  32'(qa));
    // model advances by one clock edge
    if (m_st == S_INIT || (m_st == S_IDLE && i)) begin m_af = afv; m_ae = aev; end
    if (qa) begin sb.push_back(mq.pop_front()); m_rd = (m_rd + 1) % DEPTH; m_occ--; end
    if (pa) begin mq.push_back(wdata); m_wr = (m_wr + 1) % DEPTH; m_occ++; end
    m_dv = qa;
    if (ERR_EN && ev) m_err = 1;
    case (m_st)
      S_RESET:  m_st = S_INIT;
      S_INIT:   if (!i) m_st = S_IDLE;
      S_IDLE:   if (ERR_EN && ev) m_st = S_ERROR;
                else if (pa) m_st = S_ACTIVE;
                else if (i)  m_st = S_INIT;
      S_ACTIVE: if (ERR_EN && ev) m_st = S_ERROR;
                else if (m_occ == 0) m_st = S_IDLE;
      default:  m_st = m_st;
    endcase
  endtask

  task automatic step(input bit p, input bit q, input bit i);
    @(negedge clk);
    check_regs();
    drive(p, q, i, 6, 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_regs();
    reset = 1'b1; push = 1'b0; pop = 1'b0; init = 1'b1;
    #1;
    model_reset();
    check_regs();
    @(negedge clk);
    check_regs();
    reset = 1'b0;
    drive(0, 0, 1, 6, 2);
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; push = 1'b0; pop = 1'b0;
    af_thresh = 4'd6; ae_thresh = 4'd2; wdata = '0;
    model_reset();

    // reset then init held for two cycles
    do_reset();
    step(0, 0, 1);
    step(0, 0, 0);

    // fill to full, then push into a full FIFO
    repeat (8) step(1, 0, 0);
    step(1, 0, 0);

    // drop to 4, simultaneous push+pop, then drain past empty
    repeat (4) step(0, 1, 0);
    step(1, 1, 0);
    repeat (10) step(0, 1, 0);
    step(0, 0, 0);

    // randomized traffic with occasional threshold reloads
    for (int k = 0; k < 600; k++) begin
      int pp, pq;
      bit rp, rq, ri;
      pp = (k < 150) ? 75 : (k < 300) ? 25 : 50;
      pq = 100 - pp;
      rp = ($urandom_range(0, 99) < pp);
      rq = ($urandom_range(0, 99) < pq);
      ri = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      check_regs();
      drive(rp, rq, ri, $urandom_range(0, 8), $urandom_range(0, 8));
    end
    step(0, 0, 0);

    // reset with five words held and a read in flight
    do_reset();
    step(0, 0, 1);
    step(0, 0, 0);
    repeat (6) step(1, 0, 0);
    step(0, 1, 0);
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    @(negedge clk);
    check_regs();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
